// File: rtl/lsu_mem_stage.sv
// Load/store unit sitting directly in front of the byte-addressed data memory.
// One request in flight: alignment/range check, one-cycle memory access,
// registered response held until writeback takes it.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// ACCESS | memory driven from the captured request for one cycle
// RESP   | resp_valid=1, response held until resp_ready
module lsu_mem_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [4:0]            resp_rd,
    output logic                  resp_is_load,
    output logic [1:0]            resp_err,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [1:0]            dmem_size,
    output logic                  dmem_sign,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [4:0]            rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [1:0]            dmem_size_q, dmem_size_d;
    logic                  dmem_sign_q, dmem_sign_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]            resp_rd_q, resp_rd_d;
    logic                  resp_is_load_q, resp_is_load_d;
    logic [1:0]            resp_err_q, resp_err_d;

    logic [1:0]            size_norm;
    logic [2:0]            acc_bytes;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  misalign;
    logic                  out_of_range;
    logic [1:0]            fault_err;

    // Classify the incoming request: size normalisation, alignment and range.
    // The end address is one bit wider so addresses near the top never wrap.
    always_comb begin
        size_norm = (req_size == 2'b11) ? MEM_SIZE_W : req_size;
        case (size_norm)
            MEM_SIZE_B: acc_bytes = 3'd1;
            MEM_SIZE_H: acc_bytes = 3'd2;
            default:    acc_bytes = 3'd4;
        endcase
        misalign     = ((size_norm == MEM_SIZE_H) && req_addr[0]) ||
                       ((size_norm == MEM_SIZE_W) && (req_addr[1:0] != 2'b00));
        end_addr     = {1'b0, req_addr} + (ADDR_WIDTH+1)'(acc_bytes);
        out_of_range = end_addr > (ADDR_WIDTH+1)'(MEM_BYTES);
        fault_err    = misalign ? ERR_MISALIGN : (out_of_range ? ERR_RANGE : ERR_OK);
    end

    // Next-state and next-register values; everything holds unless updated.
    // Memory-facing registers load only for requests that will really access
    // memory, so faulting requests never disturb dmem_addr/size/sign.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        rd_d           = rd_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        dmem_size_d    = dmem_size_q;
        dmem_sign_d    = dmem_sign_q;
        resp_rdata_d   = resp_rdata_q;
        resp_rd_d      = resp_rd_q;
        resp_is_load_d = resp_is_load_q;
        resp_err_d     = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d = req_we;
                    rd_d = req_rd;
                    if (fault_err != ERR_OK) begin
                        state_d        = S_RESP;
                        resp_rdata_d   = '0;
                        resp_rd_d      = req_rd;
                        resp_is_load_d = !req_we;
                        resp_err_d     = fault_err;
                    end else begin
                        state_d      = S_ACCESS;
                        dmem_addr_d  = req_addr;
                        dmem_wdata_d = req_wdata;
                        dmem_size_d  = size_norm;
                        dmem_sign_d  = req_sign;
                    end
                end
            end
            S_ACCESS: begin
                state_d        = S_RESP;
                resp_rdata_d   = we_q ? '0 : dmem_rdata;
                resp_rd_d      = rd_q;
                resp_is_load_d = !we_q;
                resp_err_d     = ERR_OK;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            we_q           <= 1'b0;
            rd_q           <= '0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            dmem_size_q    <= MEM_SIZE_W;
            dmem_sign_q    <= 1'b0;
            resp_rdata_q   <= '0;
            resp_rd_q      <= '0;
            resp_is_load_q <= 1'b0;
            resp_err_q     <= ERR_OK;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            rd_q           <= rd_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            dmem_size_q    <= dmem_size_d;
            dmem_sign_q    <= dmem_sign_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_rd_q      <= resp_rd_d;
            resp_is_load_q <= resp_is_load_d;
            resp_err_q     <= resp_err_d;
        end
    end

    // Handshake flags decode the registered state; the write strobe is
    // masked by rst so a store caught by reset in ACCESS never lands.
    always_comb begin
        req_ready    = (state_q == S_IDLE);
        resp_valid   = (state_q == S_RESP);
        dmem_we      = (state_q == S_ACCESS) && we_q && !rst;
        dmem_addr    = dmem_addr_q;
        dmem_wdata   = dmem_wdata_q;
        dmem_size    = dmem_size_q;
        dmem_sign    = dmem_sign_q;
        resp_rdata   = resp_rdata_q;
        resp_rd      = resp_rd_q;
        resp_is_load = resp_is_load_q;
        resp_err     = resp_err_q;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly upstream of the 4 KB byte-addressed data memory.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Checks alignment and address range, then drives the data memory's write-enable, address, write data, access size and sign controls for exactly one cycle.
- Registers the result and returns it to writeback over a second valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32, address width; same value as the riscv defines package.
- DATA_WIDTH, 32, data width; same value as the riscv defines package.
- MEM_BYTES, 4096, size of the data memory in bytes; addresses must satisfy addr + access_bytes <= MEM_BYTES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- req_size  in  2  mem_read_size_t: MEM_SIZE_B, MEM_SIZE_H or MEM_SIZE_W.
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend load.
- req_rd  in  5  destination register tag, passed through unchanged.
- resp_valid  out  1  response available.
- resp_ready  in  1  writeback accepts the response.
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and faults.
- resp_rd  out  5  tag of the completed request.
- resp_is_load  out  1  completed request was a load.
- resp_err  out  2  00 ok, 01 misaligned, 10 out-of-range.
- dmem_we  out  1  memory write enable.
- dmem_addr  out  ADDR_WIDTH  memory address.
- dmem_wdata  out  DATA_WIDTH  memory write data.
- dmem_size  out  2  memory access size.
- dmem_sign  out  1  memory extension control.
- dmem_rdata  in  DATA_WIDTH  memory read data; combinational with dmem_addr, dmem_size and dmem_sign.

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: drives the memory.
  - RESP: resp_valid=1.
- Reset (rst high at a clock edge), state goes to IDLE and:
  - resp_valid=0, resp_rdata=0, resp_rd=0, resp_is_load=0, resp_err=00.
  - dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_size=MEM_SIZE_W, dmem_sign=0.
  - Reset mid-operation abandons the request. A store in ACCESS whose clock edge coincides with rst high must not be written: dmem_we is gated by !rst.
- IDLE, when req_valid && req_ready:
  - Capture we, addr, wdata, size, sign and rd into request registers.
  - Evaluate faults:
    - Misaligned: H with addr[0]!=0, or W with addr[1:0]!=0.
    - Out-of-range: addr + bytes > MEM_BYTES, where bytes = 1, 2 or 4.
    - Misaligned takes priority over out-of-range.
  - Fault: go to RESP with resp_err set. The memory is never written and resp_rdata=0.
  - No fault: go to ACCESS.
- Illegal req_size (2'b11) is treated as MEM_SIZE_W.
- ACCESS, one cycle:
  - dmem_addr, dmem_size and dmem_sign come from the captured request. dmem_wdata = captured wdata.
  - dmem_we=1 only for a store, and only in this cycle.
  - At the cycle end, resp_rdata <= dmem_rdata for a load, or 0 for a store. resp_err=00.
  - Go to RESP.
- RESP:
  - resp_valid=1. All resp_* outputs hold stable until resp_valid && resp_ready.
  - On the handshake, go to IDLE and drop resp_valid the next cycle.
- req_ready=1 only in IDLE; a new request is never accepted in the same cycle that a response is taken. Throughput is one request per 3 cycles when resp_ready stays high.
- Latency: accept at edge N, ACCESS during cycle N+1, resp_valid from cycle N+2. Fault path: resp_valid from cycle N+1.
- dmem_we is 0 in every state except a store in ACCESS. Outside ACCESS, dmem_addr/size/sign keep their last value (no glitching toggles).
- Request inputs are ignored when req_ready=0.
- resp_rd and resp_is_load reflect the captured request for both faults and successes.

Test Plan:
- Word round trip: store W addr=0x100 wdata=0xDEADBEEF, then load W 0x100 -> dmem_we high exactly 1 cycle; load resp_rdata=0xDEADBEEF, resp_err=00, resp_valid 2 cycles after accept.
- Sign/zero extension: store B 0x80 at 0x200; load B sign=1 -> 0xFFFFFF80; load B sign=0 -> 0x00000080; store H 0x8001 at 0x202, load H sign=1 -> 0xFFFF8001.
- Faults:
  - Load W at 0x102 -> resp_err=01 one cycle after accept, dmem_we never asserted, resp_rdata=0.
  - Store H at 0xFFF -> resp_err=01 (misaligned wins).
  - Store W at 0xFFC -> ok.
  - Store W at 0x1000 -> resp_err=10, memory unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_* stable, req_ready=0 throughout, next request accepted only after the handshake.
- Reset mid-store: assert rst in the ACCESS cycle of store W 0x300=0x12345678 -> subsequent load 0x300 returns the prior contents, all outputs at reset values the cycle after.
- Back-to-back: 4 requests with req_valid held high and resp_ready=1 -> accepted every 3 cycles, resp_rd tags returned in order, no request dropped.
